button_event_ctrl: RTL
======================

Name: button_event_ctrl

Overview:
Multi-channel push-button controller that sequences debounce sampling for N raw switch inputs. It contains a shared sample-tick prescaler, 2-flop input synchronizers and a per-channel debounce/hold state machine. It emits level-clean outputs plus single-cycle press, release and long-press event pulses. It sits between board switch pins and the user logic (counters, FSM stepping, display mode select).

Parameters:
N_BTN, 4, number of button channels (1..16)
TICK_DIV, 100000, clk cycles per debounce sample tick (>=1; 1 = tick every cycle)
STABLE_TICKS, 8, consecutive ticks a new level must persist before acceptance (>=1)
LONG_TICKS, 1000, ticks held (counted from accepted press) before long_press fires (>STABLE_TICKS)

Ports:
clk  input  1  system clock, all logic on rising edge
rst_n  input  1  asynchronous active-low reset
raw  input  N_BTN  unsynchronized switch levels, 1 = pressed
en  input  1  1 = run; 0 = freeze prescaler and return all channels to IDLE
clean  output  N_BTN  debounced level per channel
press  output  N_BTN  1-cycle pulse on accepted 0->1
release  output  N_BTN  1-cycle pulse on accepted 1->0
long_press  output  N_BTN  1-cycle pulse when hold reaches LONG_TICKS
tick  output  1  1-cycle sample strobe (observability)

Behaviour:
- Reset (rst_n=0, async): prescaler=0, sync flops=0, all channels IDLE, counters=0; clean, press, release, long_press, tick all 0. Reset mid-press: no release pulse is generated; state is simply cleared.
- Clock is clk; reset is rst_n, asynchronous assert, active-low; all other logic is synchronous.
- Synchronizer: raw -> s1 -> s2, 2 flops per bit; the FSM sees only s2.
- Prescaler: width $clog2(TICK_DIV) (min 1). Counts 0..TICK_DIV-1 while en=1, then wraps. tick=1 (registered) on the cycle the count equals TICK_DIV-1. If en=0, count holds at 0 and tick=0.
- Per-channel FSM states: IDLE (clean=0), PRESS_PEND (clean=0), HELD (clean=1), LONG (clean=1), REL_PEND (clean=1). Each channel has stab_cnt (width clog2(STABLE_TICKS+1)) and hold_cnt (width clog2(LONG_TICKS+1)).
- FSM transitions are evaluated only on tick cycles; between ticks, state and counters hold.
- IDLE: s2=1 -> PRESS_PEND, stab_cnt=1. If STABLE_TICKS=1, go directly to HELD and emit press.
- PRESS_PEND: s2=0 -> IDLE, stab_cnt=0 (bounce rejected, no event). s2=1 and stab_cnt=STABLE_TICKS-1 -> HELD, press pulse, hold_cnt=0. Otherwise stab_cnt++.
- HELD: s2=0 -> REL_PEND, stab_cnt=1. hold_cnt counts while in HELD or REL_PEND. When hold_cnt reaches LONG_TICKS-1 -> LONG with a long_press pulse. If a release is pending in the same tick, release qualification takes priority and long_press is suppressed.
- LONG: s2=0 -> REL_PEND; hold_cnt saturates, so long_press fires at most once per press.
- REL_PEND: s2=1 -> return to the previous held state (HELD or LONG, tracked by a 1-bit flag), stab_cnt=0. s2=0 and stab_cnt=STABLE_TICKS-1 -> IDLE with release pulse. Otherwise stab_cnt++.
- Event outputs are registered. Each is high exactly 1 clk cycle, the cycle after the qualifying tick, coincident with the clean edge. press, release and long_press are mutually exclusive per channel per cycle.
- Channels are fully independent; simultaneous events on different channels all pulse in the same cycle.
- en 1->0: next cycle all channels go to IDLE, clean=0, no release pulses. en 0->1: the prescaler restarts from 0.
- Latency (raw step, no bounce): ≤ 2 + TICK_DIV*STABLE_TICKS + 1 cycles to clean/press.

Decomposition:
- Package btn_pkg: state enum (IDLE, PRESS_PEND, HELD, LONG, REL_PEND) and the counter-width helper constants.
- Sub-module btn_chan_fsm: one channel (sync + FSM + counters). Instantiated N_BTN times via generate.
- The prescaler stays in the top level and broadcasts tick.

Test Plan:
(All with TICK_DIV=4, STABLE_TICKS=3, LONG_TICKS=10, N_BTN=4.)
- Clean press: raw[0]=1 held from cycle 0 after reset release -> clean[0] rises and press[0] pulses 1 cycle at cycle ≤15. Other channels stay 0.
- Bounce reject: raw[1] toggles 1,0 every 5 cycles for 40 cycles -> clean[1]=0 and no press/release throughout. A steady 1 afterwards yields press after 3 ticks.
- Long press: hold raw[2]=1 for 60 cycles -> press[2] once. long_press[2] exactly once, 10 ticks (40 cycles) after press. clean stays 1; no second long_press.
- Release: from HELD, drop raw[0] -> release[0] pulse after 3 ticks. A glitch 0 for 1 tick during hold causes no release.
- Async reset mid-hold: rst_n=0 mid-cycle while clean[3]=1 -> all outputs 0 immediately, no release pulse. After rst_n=1 with raw held, press re-qualifies after 3 ticks.
- en control: en=0 while clean=1 -> clean=0 next cycle, tick stays 0, no events. en=1 restores, with first tick 4 cycles later.

Source files
------------

// File: rtl/btn_pkg.sv
// btn_pkg: shared state encoding and counter-width helper for the button controller
package btn_pkg;
  typedef enum logic [2:0] {IDLE, PRESS_PEND, HELD, LONG, REL_PEND} btn_state_t;
  function automatic int cw(input int x);
    return (x > 1) ? $clog2(x) : 1;
  endfunction
endpackage

// File: rtl/btn_chan_fsm.sv
// btn_chan_fsm: one button channel with 2-flop synchronizer, debounce/hold FSM and event pulses
module btn_chan_fsm
  import btn_pkg::*;
#(
  parameter int STABLE_TICKS = 8,
  parameter int LONG_TICKS   = 1000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic raw,
  input  logic en,
  input  logic tick,
  output logic clean,
  output logic press,
  output logic rel,
  output logic long_press
);
  localparam int SW = cw(STABLE_TICKS + 1);
  localparam int HW = cw(LONG_TICKS + 1);
  localparam logic [SW-1:0] S_LAST = SW'(STABLE_TICKS - 1);
  localparam logic [HW-1:0] H_LAST = HW'(LONG_TICKS - 1);
  btn_state_t st, st_n;
  logic s1, s2, was_long, was_long_n, press_n, rel_n, long_n;
  logic [SW-1:0] stab, stab_n;
  logic [HW-1:0] hold, hold_n, hold_inc;
  assign clean = (st == HELD) || (st == LONG) || (st == REL_PEND);
  assign hold_inc = (hold == H_LAST) ? hold : hold + 1'b1;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1         <= 1'b0;
      s2         <= 1'b0;
      st         <= IDLE;
      stab       <= '0;
      hold       <= '0;
      was_long   <= 1'b0;
      press      <= 1'b0;
      rel        <= 1'b0;
      long_press <= 1'b0;
    end else begin
      s1         <= raw;
      s2         <= s1;
      st         <= st_n;
      stab       <= stab_n;
      hold       <= hold_n;
      was_long   <= was_long_n;
      press      <= press_n;
      rel        <= rel_n;
      long_press <= long_n;
    end
  end
  // IDLE/HELD/LONG always carry stab=0, so STABLE_TICKS=1 qualifies on the first tick
  always_comb begin
    st_n       = st;
    stab_n     = stab;
    hold_n     = hold;
    was_long_n = was_long;
    press_n    = 1'b0;
    rel_n      = 1'b0;
    long_n     = 1'b0;
    if (!en) begin
      st_n       = IDLE;
      stab_n     = '0;
      hold_n     = '0;
      was_long_n = 1'b0;
    end else if (tick) begin
      if (!clean) begin
        if (!s2) begin
          st_n   = IDLE;
          stab_n = '0;
        end else if (stab == S_LAST) begin
          st_n       = HELD;
          stab_n     = '0;
          hold_n     = '0;
          was_long_n = 1'b0;
          press_n    = 1'b1;
        end else begin
          st_n   = PRESS_PEND;
          stab_n = stab + 1'b1;
        end
      end else begin
        hold_n = hold_inc;
        if (s2) begin
          stab_n = '0;
          if (st == REL_PEND) st_n = was_long ? LONG : HELD;
          else if (st == HELD && hold == H_LAST) begin
            st_n       = LONG;
            was_long_n = 1'b1;
            long_n     = 1'b1;
          end
        end else if (stab == S_LAST) begin
          st_n       = IDLE;
          stab_n     = '0;
          hold_n     = '0;
          was_long_n = 1'b0;
          rel_n      = 1'b1;
        end else begin
          st_n   = REL_PEND;
          stab_n = stab + 1'b1;
        end
      end
    end
  end
endmodule

// File: rtl/button_event_ctrl.sv
// button_event_ctrl: shared sample-tick prescaler feeding N independent debounce channels
module button_event_ctrl
  import btn_pkg::*;
#(
  parameter int N_BTN        = 4,
  parameter int TICK_DIV     = 100000,
  parameter int STABLE_TICKS = 8,
  parameter int LONG_TICKS   = 1000
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [N_BTN-1:0] raw,
  input  logic             en,
  output logic [N_BTN-1:0] clean,
  output logic [N_BTN-1:0] press,
  output logic [N_BTN-1:0] rel,
  output logic [N_BTN-1:0] long_press,
  output logic             tick
);
  localparam int PW = cw(TICK_DIV);
  localparam logic [PW-1:0] P_LAST = PW'(TICK_DIV - 1);
  logic [PW-1:0] pcnt;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pcnt <= '0;
      tick <= 1'b0;
    end else if (!en) begin
      pcnt <= '0;
      tick <= 1'b0;
    end else begin
      pcnt <= (pcnt == P_LAST) ? '0 : pcnt + 1'b1;
      tick <= (pcnt == P_LAST);
    end
  end
  for (genvar i = 0; i < N_BTN; i++) begin : g_ch
    btn_chan_fsm #(
      .STABLE_TICKS(STABLE_TICKS),
      .LONG_TICKS  (LONG_TICKS)
    ) u_ch (
      .clk       (clk),
      .rst_n     (rst_n),
      .raw       (raw[i]),
      .en        (en),
      .tick      (tick),
      .clean     (clean[i]),
      .press     (press[i]),
      .rel       (rel[i]),
      .long_press(long_press[i])
    );
  end
endmodule
